// File: rtl/loader_pkg.sv
// loader_pkg -- shared constants and state encoding for the framed program loader.
`default_nettype none
package loader_pkg;
   localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
   localparam logic [7:0] CMD_WRITE     = 8'h01;
   localparam logic [7:0] CMD_SET_ENTRY = 8'h02;
   localparam logic [7:0] RSP_ACK       = 8'h06;
   localparam logic [7:0] RSP_CSUM      = 8'h15;
   localparam logic [7:0] RSP_OVR       = 8'h16;
   localparam logic [7:0] RSP_BADCMD    = 8'h17;
   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_CSUM      = 3'd1;
   localparam logic [2:0] ERR_OVERRUN   = 3'd2;
   localparam logic [2:0] ERR_BADCMD    = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_ADDR = 3'd2,
      S_LEN  = 3'd3,
      S_DATA = 3'd4,
      S_CSUM = 3'd5,
      S_RESP = 3'd6
   } state_e;
endpackage
`default_nettype wire

// File: rtl/loader_byte_asm.sv
// loader_byte_asm -- assembles W/8 bytes MSB-first into a W-bit word; done strobes with the last byte,
// and word is valid (combinationally) in that same cycle.
`default_nettype none
module loader_byte_asm #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         en,
   input  logic [7:0]   byte_in,
   output logic [W-1:0] word,
   output logic         done
);
   localparam int N  = W / 8;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign done = en && (cnt_q == CW'(N - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = done ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   generate
      if (W > 8) begin : g_wide
         // Only the earlier W-8 bits need storage; the final byte is taken straight from the input.
         logic [W-9:0] shreg_q, shreg_d;

         assign word = {shreg_q, byte_in};

         always_comb begin
            shreg_d = shreg_q;
            if (en)
               shreg_d = word[W-9:0];
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               shreg_q <= '0;
            else
               shreg_q <= shreg_d;
         end
      end else begin : g_narrow
         assign word = byte_in;
      end
   endgenerate
endmodule
`default_nettype wire

// File: rtl/program_loader_burst.sv
// program_loader_burst -- framed UART program loader: burst SDRAM writes, checksum, one status byte.
// Revision 1.0
`default_nettype none
module program_loader_burst
   import loader_pkg::*;
#(
   parameter int          ADDR_W      = 32,
   parameter int          DATA_W      = 32,
   parameter int          TIMEOUT_CYC = 1_000_000,
   parameter logic [7:0]  MAGIC       = MAGIC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req,
   input  logic              rx_ack,
   input  logic [7:0]        rx_data,
   input  logic              tx_ready,
   output logic              tx_req,
   output logic [7:0]        tx_data,
   input  logic              wr_fin,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] entry_addr,
   output logic              entry_valid,
   output logic              busy,
   output logic [2:0]        err_code
);
   localparam int               BPW      = DATA_W / 8;
   localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   state_e            state_q, state_d;
   logic [7:0]        cmd_q, cmd_d, len_q, len_d, word_cnt_q, word_cnt_d;
   logic [7:0]        csum_q, csum_d, status_q, status_d;
   logic              ovr_q, ovr_d, arm_q, arm_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [ADDR_W-1:0] next_addr_q, next_addr_d;
   logic              wr_req_q, wr_req_d, tx_req_q, tx_req_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, entry_addr_q, entry_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              entry_valid_q, entry_valid_d, busy_q, busy_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic [2:0]        err_q, err_d;

   logic              rx_byte, asm_clr, addr_en, data_en, addr_done, data_done;
   logic [ADDR_W-1:0] addr_word;
   logic [DATA_W-1:0] data_word;

   assign rx_byte = rx_ack && req;
   assign asm_clr = (state_q == S_IDLE);
   assign addr_en = rx_byte && (state_q == S_ADDR);
   assign data_en = rx_byte && (state_q == S_DATA);

   loader_byte_asm #(.W(ADDR_W)) u_addr_asm (
      .clk(clk), .reset_n(reset_n), .clr(asm_clr), .en(addr_en),
      .byte_in(rx_data), .word(addr_word), .done(addr_done)
   );

   loader_byte_asm #(.W(DATA_W)) u_data_asm (
      .clk(clk), .reset_n(reset_n), .clr(asm_clr), .en(data_en),
      .byte_in(rx_data), .word(data_word), .done(data_done)
   );

   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      len_d         = len_q;
      word_cnt_d    = word_cnt_q;
      csum_d        = csum_q;
      status_d      = status_q;
      ovr_d         = ovr_q;
      arm_d         = arm_q;
      tmo_d         = tmo_q;
      next_addr_d   = next_addr_q;
      wr_req_d      = wr_req_q;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      entry_addr_d  = entry_addr_q;
      entry_valid_d = entry_valid_q;
      tx_req_d      = 1'b0;
      tx_data_d     = tx_data_q;
      err_d         = err_q;

      // A word landing in the same cycle as wr_fin takes the freed slot rather than overrunning.
      if (wr_req_q && wr_fin)
         wr_req_d = 1'b0;
      if (data_done) begin
         if (!wr_req_q || wr_fin) begin
            wr_req_d  = 1'b1;
            wr_addr_d = next_addr_q;
            wr_data_d = data_word;
         end else begin
            ovr_d = 1'b1;
         end
         next_addr_d = next_addr_q + ADDR_W'(BPW);
         word_cnt_d  = word_cnt_q + 8'd1;
      end

      if (!req) begin
         tmo_d = '0;
         if (state_q != S_IDLE && (!wr_req_q || wr_fin))
            state_d = S_IDLE;
      end else begin
         if (state_q inside {S_CMD, S_ADDR, S_LEN, S_DATA, S_CSUM}) begin
            if (rx_ack) begin
               tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_IDLE;
               err_d   = ERR_TIMEOUT;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end else begin
            tmo_d = '0;
         end

         case (state_q)
            S_IDLE: begin
               if (rx_byte && rx_data == MAGIC) begin
                  state_d = S_CMD;
                  err_d   = ERR_NONE;
                  csum_d  = 8'h00;
                  ovr_d   = 1'b0;
               end
            end
            S_CMD: begin
               if (rx_byte) begin
                  cmd_d  = rx_data;
                  csum_d = csum_q + rx_data;
                  if (rx_data == CMD_WRITE || rx_data == CMD_SET_ENTRY) begin
                     state_d = S_ADDR;
                  end else begin
                     state_d  = S_RESP;
                     status_d = RSP_BADCMD;
                     err_d    = ERR_BADCMD;
                     arm_d    = 1'b0;
                  end
               end
            end
            S_ADDR: begin
               if (rx_byte) begin
                  csum_d = csum_q + rx_data;
                  if (addr_done) begin
                     next_addr_d = addr_word;
                     state_d     = S_LEN;
                  end
               end
            end
            S_LEN: begin
               if (rx_byte) begin
                  len_d      = rx_data;
                  csum_d     = csum_q + rx_data;
                  word_cnt_d = 8'd0;
                  if (cmd_q == CMD_SET_ENTRY && rx_data != 8'd0) begin
                     state_d  = S_RESP;
                     status_d = RSP_BADCMD;
                     err_d    = ERR_BADCMD;
                     arm_d    = 1'b0;
                  end else if (rx_data == 8'd0) begin
                     state_d = S_CSUM;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (rx_byte) begin
                  csum_d = csum_q + rx_data;
                  if (data_done && (word_cnt_q + 8'd1) == len_q)
                     state_d = S_CSUM;
               end
            end
            S_CSUM: begin
               if (rx_byte) begin
                  state_d = S_RESP;
                  arm_d   = 1'b0;
                  if (rx_data != csum_q) begin
                     status_d = RSP_CSUM;
                     err_d    = ERR_CSUM;
                  end else if (ovr_q) begin
                     status_d = RSP_OVR;
                     err_d    = ERR_OVERRUN;
                  end else begin
                     status_d = RSP_ACK;
                     if (cmd_q == CMD_SET_ENTRY) begin
                        entry_addr_d  = next_addr_q;
                        entry_valid_d = 1'b1;
                     end
                  end
               end
            end
            S_RESP: begin
               // One settling cycle guarantees at least two cycles from the CSUM byte to tx_req.
               if (!arm_q) begin
                  arm_d = 1'b1;
               end else if (!wr_req_q && tx_ready) begin
                  tx_req_d  = 1'b1;
                  tx_data_d = status_q;
                  state_d   = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE) || wr_req_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cmd_q         <= '0;
         len_q         <= '0;
         word_cnt_q    <= '0;
         csum_q        <= '0;
         status_q      <= '0;
         ovr_q         <= 1'b0;
         arm_q         <= 1'b0;
         tmo_q         <= '0;
         next_addr_q   <= '0;
         wr_req_q      <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         entry_addr_q  <= '0;
         entry_valid_q <= 1'b0;
         tx_req_q      <= 1'b0;
         tx_data_q     <= '0;
         err_q         <= ERR_NONE;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         len_q         <= len_d;
         word_cnt_q    <= word_cnt_d;
         csum_q        <= csum_d;
         status_q      <= status_d;
         ovr_q         <= ovr_d;
         arm_q         <= arm_d;
         tmo_q         <= tmo_d;
         next_addr_q   <= next_addr_d;
         wr_req_q      <= wr_req_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         entry_addr_q  <= entry_addr_d;
         entry_valid_q <= entry_valid_d;
         tx_req_q      <= tx_req_d;
         tx_data_q     <= tx_data_d;
         err_q         <= err_d;
         busy_q        <= busy_d;
      end
   end

   assign tx_req      = tx_req_q;
   assign tx_data     = tx_data_q;
   assign wr_req      = wr_req_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign entry_addr  = entry_addr_q;
   assign entry_valid = entry_valid_q;
   assign busy        = busy_q;
   assign err_code    = err_q;
endmodule
`default_nettype wire

// File: tb/tb_program_loader_burst.sv
// tb_program_loader_burst -- directed and randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
`default_nettype none
module tb_program_loader_burst;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TMO    = 200;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req = 1'b0;
   logic        rx_ack = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_ready = 1'b1;
   logic        wr_fin = 1'b0;
   wire         tx_req;
   wire  [7:0]  tx_data;
   wire         wr_req;
   wire  [31:0] wr_addr;
   wire  [31:0] wr_data;
   wire  [31:0] entry_addr;
   wire         entry_valid;
   wire         busy;
   wire  [2:0]  err_code;

   always #5 clk = ~clk;

   program_loader_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .rx_ack(rx_ack), .rx_data(rx_data),
      .tx_ready(tx_ready), .tx_req(tx_req), .tx_data(tx_data), .wr_fin(wr_fin),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .entry_addr(entry_addr),
      .entry_valid(entry_valid), .busy(busy), .err_code(err_code)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          fin_delay = 0;
   logic [31:0] waddr_q[$];
   logic [31:0] wdata_q[$];
   logic [31:0] exp_waddr[$];
   logic [31:0] exp_wdata[$];
   logic [31:0] words_q[$];
   logic [7:0]  frame_q[$];
   logic [7:0]  txq[$];
   logic        tx_wr_seen;
   time         tx_t;
   time         last_byte_t;
   logic [31:0] exp_entry = 32'h0;
   logic        exp_entry_v = 1'b0;

   // SDRAM responder: logs each write request and completes it after fin_delay cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (wr_req === 1'b1) begin
            waddr_q.push_back(wr_addr);
            wdata_q.push_back(wr_data);
            repeat (fin_delay) @(negedge clk);
            wr_fin = 1'b1;
            @(negedge clk);
            wr_fin = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (tx_req === 1'b1) begin
            txq.push_back(tx_data);
            tx_t       = $time;
            tx_wr_seen = wr_req;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] tx_first();
      if (txq.size() == 0) return 8'hxx;
      return txq[0];
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data = b;
      rx_ack  = 1'b1;
      @(posedge clk);
      last_byte_t = $time;
      #1;
      rx_ack = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int gap_max);
      foreach (frame_q[i]) send_byte(frame_q[i], $urandom_range(gap_max, 0));
   endtask

   // Frame = MAGIC, CMD, ADDR[31:24..7:0], LEN, payload words MSB first, CSUM(+adj).
   task automatic build_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [7:0] adj);
      logic [7:0] sum;
      logic [7:0] b;
      sum = 8'h00;
      frame_q.delete();
      frame_q.push_back(8'hA5);
      frame_q.push_back(cmd);
      sum = sum + cmd;
      for (int i = 3; i >= 0; i--) begin
         b = addr[8*i +: 8];
         frame_q.push_back(b);
         sum = sum + b;
      end
      b = 8'(words_q.size());
      frame_q.push_back(b);
      sum = sum + b;
      foreach (words_q[k]) begin
         for (int i = 3; i >= 0; i--) begin
            b = words_q[k][8*i +: 8];
            frame_q.push_back(b);
            sum = sum + b;
         end
      end
      frame_q.push_back(sum + adj);
   endtask

   task automatic clear_obs();
      waddr_q.delete();
      wdata_q.delete();
      txq.delete();
   endtask

   task automatic wait_tx(input string tag);
      int i;
      i = 0;
      while (txq.size() == 0 && i < 1000) begin
         @(negedge clk);
         i++;
      end
      check({tag, "_tx_count"}, 64'(txq.size()), 64'd1);
   endtask

   task automatic wait_idle(input string tag);
      int i;
      i = 0;
      while (busy !== 1'b0 && i < 1000) begin
         @(negedge clk);
         i++;
      end
      check({tag, "_idle"}, 64'(busy), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_nwr"}, 64'(waddr_q.size()), 64'(exp_waddr.size()));
      for (int k = 0; k < exp_waddr.size() && k < waddr_q.size(); k++) begin
         check($sformatf("%s_wa%0d", tag, k), 64'(waddr_q[k]), 64'(exp_waddr[k]));
         check($sformatf("%s_wd%0d", tag, k), 64'(wdata_q[k]), 64'(exp_wdata[k]));
      end
   endtask

   // Model: every payload word is written at base + 4k; status depends only on checksum.
   task automatic run_write(input string tag, input logic [31:0] addr, input bit bad,
                            input int gap_max, input bit hold);
      build_frame(8'h01, addr, bad ? 8'h01 : 8'h00);
      exp_waddr.delete();
      exp_wdata.delete();
      foreach (words_q[k]) begin
         exp_waddr.push_back(addr + 32'(4 * k));
         exp_wdata.push_back(words_q[k]);
      end
      clear_obs();
      if (hold) tx_ready = 1'b0;
      send_frame(gap_max);
      if (hold) begin
         repeat (10) @(negedge clk);
         check({tag, "_tx_held"}, 64'(txq.size()), 64'd0);
         tx_ready = 1'b1;
      end
      wait_tx(tag);
      check({tag, "_status"}, 64'(tx_first()), bad ? 64'h15 : 64'h06);
      check({tag, "_err"}, 64'(err_code), bad ? 64'd1 : 64'd0);
      wait_idle(tag);
      check_writes(tag);
      check({tag, "_entry_v"}, 64'(entry_valid), 64'(exp_entry_v));
   endtask

   initial begin
      logic [7:0] g;
      int lat;
      req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_req", 64'(tx_req), 64'd0);
      check("rst_wr_req", 64'(wr_req), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err_code), 64'd0);
      check("rst_entry", {31'd0, entry_valid, entry_addr}, 64'd0);
      check("rst_wr", {wr_addr, wr_data}, 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic burst write, with TX stalled for a while.
      fin_delay = 1;
      words_q = {32'h11223344, 32'h55667788};
      run_write("wr_good", 32'h0000_0100, 1'b0, 1, 1'b1);
      run_write("wr_badcs", 32'h0000_0100, 1'b1, 1, 1'b0);

      // Randomized frames, optionally preceded by stray non-MAGIC bytes.
      for (int it = 0; it < 8; it++) begin
         int len;
         logic [31:0] a;
         len = $urandom_range(4, 0);
         a = (it == 3) ? 32'hFFFF_FFF8 : $urandom;
         words_q.delete();
         for (int k = 0; k < len; k++) words_q.push_back($urandom);
         fin_delay = $urandom_range(2, 0);
         for (int j = $urandom_range(2, 0); j > 0; j--) begin
            g = 8'($urandom_range(255, 0));
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, 0);
         end
         run_write($sformatf("rnd%0d", it), a, 1'($urandom_range(1, 0)), 2, 1'b0);
      end

      // Overrun: second word completes while the first write is still outstanding.
      fin_delay = 40;
      words_q = {32'hCAFEF00D, 32'hDEADBEEF};
      build_frame(8'h01, 32'h0000_0200, 8'h00);
      exp_waddr = {32'h0000_0200};
      exp_wdata = {32'hCAFEF00D};
      clear_obs();
      send_frame(0);
      wait_tx("ovr");
      check("ovr_status", 64'(tx_first()), 64'h16);
      check("ovr_err", 64'(err_code), 64'd2);
      check("ovr_tx_after_wr", 64'(tx_wr_seen), 64'd0);
      wait_idle("ovr");
      check_writes("ovr");
      fin_delay = 0;

      // SET_ENTRY good, with response latency check.
      words_q.delete();
      build_frame(8'h02, 32'h0000_2000, 8'h00);
      clear_obs();
      send_frame(0);
      wait_tx("ent");
      exp_entry = 32'h0000_2000;
      exp_entry_v = 1'b1;
      check("ent_status", 64'(tx_first()), 64'h06);
      check("ent_addr", 64'(entry_addr), 64'(exp_entry));
      check("ent_valid", 64'(entry_valid), 64'd1);
      lat = int'((tx_t - 5 - last_byte_t) / 10);
      check("ent_latency_ge2", 64'(lat >= 2), 64'd1);
      wait_idle("ent");

      // Unknown command.
      frame_q = {8'hA5, 8'h09};
      clear_obs();
      send_frame(0);
      wait_tx("badcmd");
      check("badcmd_status", 64'(tx_first()), 64'h17);
      check("badcmd_err", 64'(err_code), 64'd3);
      wait_idle("badcmd");
      check("badcmd_nwr", 64'(waddr_q.size()), 64'd0);

      // SET_ENTRY with nonzero LEN is rejected and leaves the entry alone.
      frame_q = {8'hA5, 8'h02, 8'h00, 8'h00, 8'h30, 8'h00, 8'h01};
      clear_obs();
      send_frame(0);
      wait_tx("entlen");
      check("entlen_status", 64'(tx_first()), 64'h17);
      check("entlen_err", 64'(err_code), 64'd3);
      check("entlen_entry", 64'(entry_addr), 64'(exp_entry));
      wait_idle("entlen");

      // Timeout after a partial address.
      frame_q = {8'hA5, 8'h01, 8'h12, 8'h34, 8'h56};
      clear_obs();
      send_frame(0);
      repeat (TMO - 50) @(negedge clk);
      check("tmo_busy_mid", 64'(busy), 64'd1);
      repeat (80) @(negedge clk);
      check("tmo_busy_end", 64'(busy), 64'd0);
      check("tmo_err", 64'(err_code), 64'd4);
      check("tmo_no_tx", 64'(txq.size()), 64'd0);

      // err_code clears on the next MAGIC; then complete a SET_ENTRY frame.
      @(posedge clk);
      #1;
      send_byte(8'hA5, 0);
      @(negedge clk);
      check("err_clr_magic", 64'(err_code), 64'd0);
      frame_q = {8'h02, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h42};
      send_frame(0);
      wait_tx("ent2");
      exp_entry = 32'h0000_4000;
      check("ent2_status", 64'(tx_first()), 64'h06);
      check("ent2_addr", 64'(entry_addr), 64'(exp_entry));
      wait_idle("ent2");

      // req low aborts a frame silently and ignores RX.
      frame_q = {8'hA5, 8'h01, 8'h00};
      clear_obs();
      send_frame(0);
      req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      send_byte(8'hA5, 2);
      @(negedge clk);
      check("reqlow_busy", 64'(busy), 64'd0);
      check("reqlow_no_tx", 64'(txq.size()), 64'd0);
      req = 1'b1;
      @(posedge clk);
      #1;

      // Asynchronous reset while a write is outstanding.
      fin_delay = 40;
      words_q = {32'hA1B2C3D4, 32'h0F1E2D3C};
      build_frame(8'h01, 32'h0000_0800, 8'h00);
      for (int i = 0; i < 11; i++) send_byte(frame_q[i], 0);
      repeat (2) @(negedge clk);
      check("rst_mid_wrreq_pre", 64'(wr_req), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_mid_wrreq", 64'(wr_req), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_entry", {31'd0, entry_valid, entry_addr}, 64'd0);
      check("rst_mid_err_tx", {err_code, tx_req, tx_data}, 64'd0);
      #3;
      reset_n = 1'b1;
      exp_entry = 32'h0;
      exp_entry_v = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      fin_delay = 1;
      words_q = {32'h01020304, 32'h05060708, 32'h090A0B0C};
      run_write("post_rst", 32'h0000_1000, 1'b0, 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
